// File: rtl/playback_sequencer.sv
// Playback sequencer: owns the bit-rate divider and the bit/packet counters, fetches
// ROM words, strobes the packet serializer and gates the PWM enable.
module playback_sequencer #(
  parameter int BIT_DIV      = 400,
  parameter int BITS_PER_PKT = 32,
  parameter int NUM_PACKETS  = 937,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              playBtnEN,
  input  logic              pauseBtnEN,
  input  logic              stopBtnEN,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              ser_load,
  output logic              ser_shift,
  output logic [8:0]        big_count,
  output logic [4:0]        bit_count,
  output logic [9:0]        packet_count,
  output logic              audEnPWM,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, PLAY, PAUSE} state_t;

  localparam logic [8:0] BIG_LAST = 9'(BIT_DIV - 1);
  localparam logic [8:0] BIG_PRE  = 9'(BIT_DIV - 3);
  localparam logic [4:0] BIT_LAST = 5'(BITS_PER_PKT - 1);
  localparam logic [9:0] PKT_LAST = 10'(NUM_PACKETS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              rd_nx, load_nx, shift_nx, done_nx;
  logic [8:0]        big_nx;
  logic [4:0]        bit_nx;
  logic [9:0]        pkt_nx;

  // Every output is registered from the next-state values, so a strobe appears
  // in the same cycle as the counter values it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      ser_load     <= 1'b0;
      ser_shift    <= 1'b0;
      big_count    <= '0;
      bit_count    <= '0;
      packet_count <= '0;
      audEnPWM     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      mem_addr     <= addr_nx;
      mem_rd       <= rd_nx;
      ser_load     <= load_nx;
      ser_shift    <= shift_nx;
      big_count    <= big_nx;
      bit_count    <= bit_nx;
      packet_count <= pkt_nx;
      audEnPWM     <= (state_nx == PLAY);
      busy         <= (state_nx != IDLE);
      done         <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    rd_nx    = 1'b0;
    load_nx  = 1'b0;
    shift_nx = 1'b0;
    done_nx  = 1'b0;
    big_nx   = big_count;
    bit_nx   = bit_count;
    pkt_nx   = packet_count;

    case (state)
      IDLE: begin
        big_nx = '0;
        bit_nx = '0;
        pkt_nx = '0;
        if (playBtnEN) begin
          state_nx = FETCH0;
          rd_nx    = 1'b1;
          addr_nx  = '0;
        end
      end
      FETCH0: begin
        if (stopBtnEN) begin
          state_nx = IDLE;
        end else begin
          state_nx = FETCH1;
          load_nx  = 1'b1;
        end
      end
      FETCH1: begin
        state_nx = stopBtnEN ? IDLE : PLAY;
      end
      PLAY: begin
        if (stopBtnEN) begin
          state_nx = IDLE;
          big_nx   = '0;
          bit_nx   = '0;
          pkt_nx   = '0;
        end else begin
          // Prefetch lands two cycles ahead of the packet-boundary load.
          if (big_count == BIG_PRE && bit_count == BIT_LAST && packet_count < PKT_LAST) begin
            rd_nx   = 1'b1;
            addr_nx = ADDR_W'(packet_count + 10'd1);
          end
          big_nx = big_count + 9'd1;
          if (big_count == BIG_LAST) begin
            big_nx = '0;
            if (bit_count < BIT_LAST) begin
              bit_nx   = bit_count + 5'd1;
              shift_nx = 1'b1;
            end else if (packet_count < PKT_LAST) begin
              bit_nx  = '0;
              pkt_nx  = packet_count + 10'd1;
              load_nx = 1'b1;
            end else begin
              bit_nx   = '0;
              pkt_nx   = '0;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end
          end
          if (pauseBtnEN && state_nx == PLAY) begin
            state_nx = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (stopBtnEN) begin
          state_nx = IDLE;
          big_nx   = '0;
          bit_nx   = '0;
          pkt_nx   = '0;
        end else if (playBtnEN) begin
          state_nx = PLAY;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: a small-parameter instance checked every cycle against a
// tick-based model, plus a default-parameter instance for first-bit timing.
module tb_playback_sequencer;

  localparam int BD    = 4;
  localparam int BP    = 4;
  localparam int NP    = 3;
  localparam int PK    = BD * BP;
  localparam int TOTAL = PK * NP;

  localparam int M_IDLE  = 0;
  localparam int M_F0    = 1;
  localparam int M_F1    = 2;
  localparam int M_PLAY  = 3;
  localparam int M_PAUSE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd, ser_load, ser_shift, audEnPWM, busy, done;
  logic [8:0]  big_count;
  logic [4:0]  bit_count;
  logic [9:0]  packet_count;

  logic        d_play = 1'b0, d_pause = 1'b0, d_stop = 1'b0;
  logic [15:0] d_mem_addr;
  logic        d_mem_rd, d_ser_load, d_ser_shift, d_audEnPWM, d_busy, d_done;
  logic [8:0]  d_big_count;
  logic [4:0]  d_bit_count;
  logic [9:0]  d_packet_count;

  int errors = 0;
  int checks = 0;

  // Model: the position in the clip is a single PLAY-tick index; counters derive from it.
  int mode = M_IDLE;
  int tick = 0;
  int e_rd = 0, e_addr = 0, e_load = 0, e_shift = 0, e_done = 0;
  int n_rd = 0, n_load = 0, n_shift = 0, n_done = 0, n_en = 0;

  playback_sequencer #(.BIT_DIV(BD), .BITS_PER_PKT(BP), .NUM_PACKETS(NP), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .playBtnEN(play), .pauseBtnEN(pause), .stopBtnEN(stop),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .ser_load(ser_load), .ser_shift(ser_shift),
    .big_count(big_count), .bit_count(bit_count), .packet_count(packet_count),
    .audEnPWM(audEnPWM), .busy(busy), .done(done)
  );

  playback_sequencer dut_def (
    .clk(clk), .reset(reset), .playBtnEN(d_play), .pauseBtnEN(d_pause), .stopBtnEN(d_stop),
    .mem_addr(d_mem_addr), .mem_rd(d_mem_rd), .ser_load(d_ser_load), .ser_shift(d_ser_shift),
    .big_count(d_big_count), .bit_count(d_bit_count), .packet_count(d_packet_count),
    .audEnPWM(d_audEnPWM), .busy(d_busy), .done(d_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; tick = 0;
    e_rd = 0; e_addr = 0; e_load = 0; e_shift = 0; e_done = 0;
  endtask

  task automatic model_step(input bit p, input bit pa, input bit s);
    int big, bitn, pkt;
    e_rd = 0; e_load = 0; e_shift = 0; e_done = 0;
    case (mode)
      M_IDLE: if (p) begin mode = M_F0; tick = 0; e_rd = 1; e_addr = 0; end
      M_F0: if (s) begin mode = M_IDLE; tick = 0; end else begin mode = M_F1; e_load = 1; end
      M_F1: if (s) begin mode = M_IDLE; tick = 0; end else mode = M_PLAY;
      M_PLAY: begin
        if (s) begin
          mode = M_IDLE; tick = 0;
        end else begin
          big = tick % BD; bitn = (tick / BD) % BP; pkt = tick / PK;
          if (big == BD - 3 && bitn == BP - 1 && pkt < NP - 1) begin e_rd = 1; e_addr = pkt + 1; end
          tick++;
          if (tick == TOTAL) begin tick = 0; e_done = 1; mode = M_IDLE; end
          else if (tick % PK == 0) e_load = 1;
          else if (tick % BD == 0) e_shift = 1;
          if (mode == M_PLAY && pa) mode = M_PAUSE;
        end
      end
      M_PAUSE: if (s) begin mode = M_IDLE; tick = 0; end else if (p) mode = M_PLAY;
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic checkOutput();
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    if (e_rd != 0) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("ser_load", 32'(ser_load), 32'(e_load));
    chk("ser_shift", 32'(ser_shift), 32'(e_shift));
    chk("big_count", 32'(big_count), 32'(tick % BD));
    chk("bit_count", 32'(bit_count), 32'((tick / BD) % BP));
    chk("packet_count", 32'(packet_count), 32'(tick / PK));
    chk("audEnPWM", 32'(audEnPWM), 32'(mode == M_PLAY));
    chk("busy", 32'(busy), 32'(mode != M_IDLE));
    chk("done", 32'(done), 32'(e_done));
  endtask

  // Called at a falling edge; drives one cycle of pulses and checks after the next rise.
  task automatic applyStimulus(input bit p, input bit pa, input bit s);
    play = p; pause = pa; stop = s;
    model_step(p, pa, s);
    @(negedge clk);
    play = 1'b0; pause = 1'b0; stop = 1'b0;
    d_play = 1'b0; d_pause = 1'b0; d_stop = 1'b0;
    checkOutput();
    n_rd += int'(mem_rd); n_load += int'(ser_load); n_shift += int'(ser_shift);
    n_done += int'(done); n_en += int'(audEnPWM);
  endtask

  task automatic clear_counts();
    n_rd = 0; n_load = 0; n_shift = 0; n_done = 0; n_en = 0;
  endtask

  task automatic check_clip_totals(input string tag);
    chk({tag, "_rd"}, 32'(n_rd), 32'd3);
    chk({tag, "_load"}, 32'(n_load), 32'd3);
    chk({tag, "_shift"}, 32'(n_shift), 32'd9);
    chk({tag, "_done"}, 32'(n_done), 32'd1);
    chk({tag, "_play_cycles"}, 32'(n_en), 32'd48);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic run_to(input int pk, input int bt, input int bg);
    int n = 0;
    while (!((tick / PK) == pk && ((tick / BD) % BP) == bt && (tick % BD) == bg) && n < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("run_to_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int dsh;
    bit rp, rpa, rs;
    int r;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_counts", 32'({big_count, bit_count, packet_count}), 32'd0);
    chk("rst_strobes", 32'({ser_load, ser_shift, audEnPWM, busy, done}), 32'd0);
    chk("rst_def_outputs", 32'({d_mem_rd, d_ser_load, d_ser_shift, d_audEnPWM, d_busy, d_done}), 32'd0);
    chk("rst_def_counts", 32'({d_big_count, d_bit_count, d_packet_count}), 32'd0);
    reset = 1'b1;

    // Default parameters: first-bit latency and first shift after 400 cycles.
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    d_play = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("def_fetch_rd", 32'(d_mem_rd), 32'd1);
    chk("def_fetch_addr", 32'(d_mem_addr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("def_load", 32'(d_ser_load), 32'd1);
    chk("def_load_rd", 32'(d_mem_rd), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("def_pwm_on", 32'(d_audEnPWM), 32'd1);
    chk("def_big0", 32'(d_big_count), 32'd0);
    dsh = 0;
    for (int i = 1; i <= 399; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      dsh += int'(d_ser_shift);
    end
    chk("def_big399", 32'(d_big_count), 32'd399);
    chk("def_no_early_shift", 32'(dsh), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("def_first_shift", 32'(d_ser_shift), 32'd1);
    chk("def_bit1", 32'({d_big_count, d_bit_count}), 32'({9'd0, 5'd1}));
    d_stop = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("def_stop_busy", 32'({d_busy, d_audEnPWM, d_done}), 32'd0);

    // Full uninterrupted clip.
    clear_counts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);
    check_clip_totals("full");

    // Pause at (1,2,1), hold 20 cycles, resume.
    clear_counts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    run_to(1, 2, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    chk("pause_counts", 32'({packet_count, bit_count, big_count}), 32'({10'd1, 5'd2, 9'd2}));
    chk("pause_pwm", 32'(audEnPWM), 32'd0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
    chk("pause_frozen", 32'({packet_count, bit_count, big_count}), 32'({10'd1, 5'd2, 9'd2}));
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("resume_counts", 32'({packet_count, bit_count, big_count}), 32'({10'd1, 5'd2, 9'd3}));
    repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);
    check_clip_totals("pause");

    // Stop and pause in the same PLAY cycle.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    chk("stop_pause_state", 32'({busy, audEnPWM, done}), 32'd0);
    chk("stop_pause_counts", 32'({packet_count, bit_count, big_count}), 32'd0);

    // Asynchronous reset in the middle of PLAY, then restart from packet 0.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (23) applyStimulus(1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_counts", 32'({packet_count, bit_count, big_count}), 32'd0);
    chk("async_rst_strobes", 32'({mem_rd, ser_load, ser_shift, audEnPWM, busy, done}), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_counts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);
    check_clip_totals("restart");

    // Ignored pulses: pause in FETCH0, repeated play while playing.
    clear_counts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) applyStimulus((i % 5 == 0) && (i < 45), 1'b0, 1'b0);
    check_clip_totals("ignored");

    // Randomized single-button pulses against the model.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      rp = (r < 8); rpa = (r >= 8 && r < 12); rs = (r >= 12 && r < 14);
      applyStimulus(rp, rpa, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
- Timing and control master for the audio playback path.
- Owns the bit-rate divider, the bit-in-packet counter and the packet counter, and drives the audio ROM read port.
- Issues load/shift strobes to the packet serializer and gates the PWM enable.
- Handles play/pause/stop button pulses.
- Sits between the debounced button logic and the ROM → serializer → PWM datapath.

Parameters:
BIT_DIV, 400, clock cycles per audio bit; ≥ 4.
BITS_PER_PKT, 32, bits per ROM word/packet.
NUM_PACKETS, 937, packets in one clip.
ADDR_W, 16, ROM address width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
playBtnEN  input  1  one-cycle play pulse
pauseBtnEN  input  1  one-cycle pause pulse
stopBtnEN  input  1  one-cycle stop pulse
mem_addr  output  ADDR_W  ROM address
mem_rd  output  1  ROM read strobe; data valid the following cycle and held until the next mem_rd
ser_load  output  1  serializer parallel-load strobe
ser_shift  output  1  serializer shift strobe
big_count  output  9  divider count, 0..BIT_DIV-1
bit_count  output  5  bit index in packet, 0..BITS_PER_PKT-1
packet_count  output  10  current packet, 0..NUM_PACKETS-1
audEnPWM  output  1  PWM enable
busy  output  1  high whenever state ≠ IDLE
done  output  1  one-cycle pulse at natural end of clip

Behaviour:
- All outputs are registered and go to 0 on reset; the FSM resets to IDLE. Reset is asynchronous and takes effect mid-operation with no done pulse.
- States: IDLE, FETCH0, FETCH1, PLAY, PAUSE.
- IDLE:
  - counters held at 0; strobes 0; audEnPWM=0.
  - playBtnEN → FETCH0.
- FETCH0 (one cycle): mem_rd=1, mem_addr=packet_count (0) → FETCH1.
- FETCH1 (one cycle): ser_load=1 → PLAY.
  - Play-to-first-bit latency: 3 cycles after the play pulse.
- PLAY: audEnPWM=1; big_count increments every cycle.
  - big_count==BIT_DIV-3, bit_count==BITS_PER_PKT-1, packet_count<NUM_PACKETS-1: mem_rd=1, mem_addr=packet_count+1 (prefetch).
  - big_count==BIT_DIV-1, bit_count<BITS_PER_PKT-1: big_count→0, bit_count+1, ser_shift=1.
  - big_count==BIT_DIV-1, bit_count==BITS_PER_PKT-1, packet not last: big_count→0, bit_count→0, packet_count+1, ser_load=1. ser_shift=0 in this cycle.
  - Same condition on the last packet: all counters→0, done=1, audEnPWM=0 next cycle, go to IDLE.
- Button priority: stop > pause > play.
  - stopBtnEN in any non-IDLE state → IDLE, counters cleared, no done.
  - pauseBtnEN in PLAY → PAUSE. The PLAY actions of that cycle (counter update, strobes) still complete.
  - pauseBtnEN in FETCH0/FETCH1/PAUSE/IDLE is ignored.
  - playBtnEN in PLAY/FETCH is ignored.
- PAUSE:
  - counters frozen; strobes 0; audEnPWM=0.
  - playBtnEN → PLAY, resuming from the frozen counts.
  - A prefetch issued in the pause cycle is safe because ROM data holds until the next read.
- Simultaneous pulses: the higher-priority pulse wins and the others are dropped.
- A stop pulse coinciding with the final-bit cycle: the stop wins and done is not pulsed.
- Counter widths:
  - mem_addr is packet_count zero-extended to ADDR_W.
  - The counters never exceed their parameter limits and no wrap-around beyond a limit is permitted.

Test Plan:
- Defaults, playBtnEN pulse at cycle 10 → mem_rd@11 (addr 0), ser_load@12, audEnPWM rises @13 (first PLAY cycle); first ser_shift when big_count reaches 399, 400 cycles after PLAY entry.
- BIT_DIV=4, BITS_PER_PKT=4, NUM_PACKETS=3, full run → exactly 2 prefetch mem_rd (addr 1, 2), 3 ser_load total, 9 ser_shift, single done pulse, back in IDLE with busy=0, 48 PLAY cycles.
- Small params, pauseBtnEN at packet 1, bit 2, big_count 1 → counters freeze at (1,2,2), audEnPWM=0; playBtnEN 20 cycles later → resumes at (1,2,3), total strobe counts unchanged vs the uninterrupted run.
- Small params, stopBtnEN and pauseBtnEN in the same PLAY cycle → IDLE next cycle, counters 0, done=0.
- reset asserted low mid-PLAY (asynchronous, between clock edges) → all outputs 0 immediately; after release, playBtnEN restarts from packet 0.
- playBtnEN repeated in PLAY and pauseBtnEN in FETCH0 → no state or counter perturbation vs the baseline run.
